// File: rtl/regfile_init_pkg.sv
// regfile_init_pkg: shared encodings and default widths for the register
// file initiator.
//   op_e    : block operation encodings (CLEAR, FILL, COPY, CMP)
//   state_e : initiator FSM states
//   DFLT_*  : default widths for a 512 x 64-bit register file
package regfile_init_pkg;

  localparam int DFLT_ADDR_W = 9;   // 512 registers
  localparam int DFLT_DATA_W = 64;
  localparam int DFLT_LEN_W  = 10;  // element count 0..512

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_FILL  = 2'b01,
    OP_COPY  = 2'b10,
    OP_CMP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rf_addr_counter.sv
// rf_addr_counter: element index counter for the initiator.
//   clk, rst_n          : clock, async active-low reset
//   load                : restart the index at 0 (command accept)
//   advance             : step to the next element
//   len                 : latched element count (>= 1 while advancing)
//   src_base, dst_base  : base addresses
//   src_addr, dst_addr  : base + index, wrapping modulo 2^AW
//   last                : current index is element len-1
module rf_addr_counter
  import regfile_init_pkg::*;
#(
  parameter int AW = DFLT_ADDR_W,
  parameter int LW = DFLT_LEN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          advance,
  input  logic [LW-1:0] len,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic [AW-1:0] src_addr,
  output logic [AW-1:0] dst_addr,
  output logic          last
);

  logic [LW-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       idx <= '0;
    else if (load)    idx <= '0;
    else if (advance) idx <= idx + LW'(1);
  end

  // Dropping the index MSB makes the sum wrap around the register file.
  assign src_addr = src_base + idx[AW-1:0];
  assign dst_addr = dst_base + idx[AW-1:0];
  assign last     = (idx == len - LW'(1));

endmodule

// File: rtl/regfile_initiator.sv
// regfile_initiator: command-driven block engine for the register file.
// Clears, fills, copies or compares a register range, one element per clock.
//   Clk, Rst_n                : clock, async active-low reset
//   cmd_valid/cmd_ready       : command handshake (ready only in IDLE)
//   cmd_op/src/dst/len/data   : command fields, sampled at accept only
//   busy, done, mismatch_cnt  : status; done is a one-cycle pulse
//   read_reg1/2, read_data1/2 : register file read ports (data is comb.)
//   write_reg/write_data      : register file write port
//   reg_write, En             : write strobe and enable
//   checksum                  : only with REGFILE_INIT_CHECKSUM_EN; XOR of
//                               issued write data (CMP: of read_data1)
module regfile_initiator
  import regfile_init_pkg::*;
#(
  parameter int ADDR_W = DFLT_ADDR_W,
  parameter int DATA_W = DFLT_DATA_W,
  parameter int LEN_W  = DFLT_LEN_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] read_reg1,
  output logic [ADDR_W-1:0] read_reg2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic              En
`ifdef REGFILE_INIT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_e            state;
  op_e               op_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic              last;
  logic              run, accept;
  logic [DATA_W-1:0] wdata;

  assign run    = (state == RUN);
  assign accept = (state == IDLE) && cmd_valid;

  rf_addr_counter #(.AW(ADDR_W), .LW(LEN_W)) u_cnt (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (accept),
    .advance  (run),
    .len      (len_q),
    .src_base (src_q),
    .dst_base (dst_q),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .last     (last)
  );

  always_comb begin
    wdata = '0;
    unique case (op_q)
      OP_CLEAR: wdata = '0;
      OP_FILL:  wdata = data_q;
      OP_COPY:  wdata = read_data1;  // same-cycle pass-through
      OP_CMP:   wdata = '0;
      default:  wdata = '0;
    endcase
  end

  // Everything below decodes the state register, so an async reset
  // removes the write strobe and addresses immediately.
  assign cmd_ready  = (state == IDLE);
  assign busy       = run;
  assign done       = (state == DONE);
  assign En         = run && (op_q != OP_CMP);
  assign reg_write  = En;
  assign read_reg1  = run ? src_addr : '0;
  assign read_reg2  = run ? dst_addr : '0;
  assign write_reg  = run ? dst_addr : '0;
  assign write_data = run ? wdata    : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      op_q         <= OP_CLEAR;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      data_q       <= '0;
      mismatch_cnt <= '0;
`ifdef REGFILE_INIT_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (cmd_valid) begin
          op_q         <= op_e'(cmd_op);
          src_q        <= cmd_src;
          dst_q        <= cmd_dst;
          len_q        <= cmd_len;
          data_q       <= cmd_data;
          mismatch_cnt <= '0;
`ifdef REGFILE_INIT_CHECKSUM_EN
          checksum     <= '0;
`endif
          state        <= (cmd_len == '0) ? DONE : RUN;
        end
        RUN: begin
          if (op_q == OP_CMP && read_data1 != read_data2)
            mismatch_cnt <= mismatch_cnt + LEN_W'(1);
`ifdef REGFILE_INIT_CHECKSUM_EN
          checksum <= checksum ^ ((op_q == OP_CMP) ? read_data1 : wdata);
`endif
          if (last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_initiator.sv
module tb_regfile_initiator;
  import regfile_init_pkg::*;

  localparam int AW = 9, DW = 64, LW = 10;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_src, cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_data;
  logic          busy, done;
  logic [LW-1:0] mismatch_cnt;
  logic [AW-1:0] read_reg1, read_reg2, write_reg;
  logic [DW-1:0] read_data1, read_data2, write_data;
  logic          reg_write, En;
`ifdef REGFILE_INIT_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 Clk = ~Clk;

  regfile_initiator dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_reg(write_reg), .write_data(write_data),
    .reg_write(reg_write), .En(En)
`ifdef REGFILE_INIT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Register file model: comb. reads, write at the rising edge.
  logic [DW-1:0] mem [0:511];
  logic          mem_init_done;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  function automatic logic [DW-1:0] init_val(input int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  assign read_data1 = mem[read_reg1];
  assign read_data2 = mem[read_reg2];

  always @(posedge Clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
    end else if (reg_write) begin
      mem[write_reg] <= write_data;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
  end

  // Cumulative activity counters sampled mid-cycle.
  int wr_tot = 0, en_tot = 0, done_tot = 0, busy_tot = 0;
  always @(negedge Clk) begin
    if (reg_write) wr_tot++;
    if (En)        en_tot++;
    if (done)      done_tot++;
    if (busy)      busy_tot++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command; lat = cycles from accept edge to the done cycle
  // (-1 if done never came within the budget).
  task automatic run_cmd(input logic [1:0] op, input int src, input int dst,
                         input int len, input logic [63:0] data, output int lat);
    @(negedge Clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = AW'(src);
    cmd_dst   = AW'(dst);
    cmd_len   = LW'(len);
    cmd_data  = data;
    @(posedge Clk);
    #1;
    // Scramble fields after accept; the DUT must ignore them.
    cmd_valid = 1'b0;
    cmd_src   = 9'd300;
    cmd_dst   = 9'd301;
    cmd_data  = 64'hDEAD_BEEF;
    lat = -1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge Clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    @(negedge Clk);
    chk("ready_after_done", cmd_ready, 1);
    #1;
  endtask

  int lat, w0, e0, d0, b0;

  initial begin
    Rst_n = 1'b0; mem_init_done = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_data = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mm", mismatch_cnt, 0);
    chk("rst_en", En, 0);
    chk("rst_we", reg_write, 0);
    chk("rst_wreg", write_reg, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_rreg1", read_reg1, 0);
    chk("rst_rreg2", read_reg2, 0);
    mem_init_done = 1'b1;
    Rst_n = 1'b1;
    @(negedge Clk);

    // FILL dst=10 len=4 data=59
    w0 = wr_tot; e0 = en_tot; d0 = done_tot; b0 = busy_tot;
    run_cmd(OP_FILL, 0, 10, 4, 64'd59, lat);
    chk("fill_lat", lat, 5);
    chk("fill_wr", wr_tot - w0, 4);
    chk("fill_en", en_tot - e0, 4);
    chk("fill_busy", busy_tot - b0, 4);
    chk("fill_done1", done_tot - d0, 1);
    for (int i = 10; i < 14; i++) chk("fill_mem", mem[i], 59);
    chk("fill_below", mem[9], init_val(9));
    chk("fill_above", mem[14], init_val(14));

    // COPY 10..13 -> 20..23, then CMP equal
    run_cmd(OP_COPY, 10, 20, 4, 64'd0, lat);
    chk("copy_lat", lat, 5);
    for (int i = 20; i < 24; i++) chk("copy_mem", mem[i], 59);
    chk("copy_above", mem[24], init_val(24));
    w0 = wr_tot; e0 = en_tot;
    run_cmd(OP_CMP, 10, 20, 4, 64'd0, lat);
    chk("cmp0_mm", mismatch_cnt, 0);
    chk("cmp0_wr", wr_tot - w0, 0);

    // Backdoor 128 into reg 22, CMP finds one mismatch
    @(negedge Clk);
    bd_we = 1'b1; bd_addr = 9'd22; bd_data = 64'd128;
    @(negedge Clk);
    bd_we = 1'b0;
    w0 = wr_tot; e0 = en_tot;
    run_cmd(OP_CMP, 10, 20, 4, 64'd0, lat);
    chk("cmp1_lat", lat, 5);
    chk("cmp1_mm", mismatch_cnt, 1);
    chk("cmp1_wr", wr_tot - w0, 0);
    chk("cmp1_en", en_tot - e0, 0);
    chk("cmp1_reg22", mem[22], 128);
    repeat (3) @(negedge Clk);
    chk("cmp1_hold", mismatch_cnt, 1);

    // CLEAR with address wrap
    run_cmd(OP_CLEAR, 0, 510, 4, 64'd0, lat);
    chk("clr_mm_cleared", mismatch_cnt, 0);
    chk("clr_510", mem[510], 0);
    chk("clr_511", mem[511], 0);
    chk("clr_0", mem[0], 0);
    chk("clr_1", mem[1], 0);
    chk("clr_2", mem[2], init_val(2));
    chk("clr_509", mem[509], init_val(509));

    // Zero-length command
    e0 = en_tot; d0 = done_tot;
    run_cmd(OP_CLEAR, 0, 3, 0, 64'd0, lat);
    chk("len0_lat", lat, 1);
    chk("len0_en", en_tot - e0, 0);
    chk("len0_done1", done_tot - d0, 1);
    chk("len0_mem3", mem[3], init_val(3));

    // Overlapping ascending COPY propagates element 30
    run_cmd(OP_COPY, 30, 31, 3, 64'd0, lat);
    chk("ovl_30", mem[30], init_val(30));
    chk("ovl_31", mem[31], init_val(30));
    chk("ovl_32", mem[32], init_val(30));
    chk("ovl_33", mem[33], init_val(30));
    chk("ovl_34", mem[34], init_val(34));

    // Reset in the 2nd RUN cycle of FILL len=8
    d0 = done_tot;
    @(negedge Clk);
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_src = '0; cmd_dst = 9'd40;
    cmd_len = 10'd8; cmd_data = 64'd77;
    @(posedge Clk);          // accept edge
    #1 cmd_valid = 1'b0;
    @(posedge Clk);          // element 0 committed, element 1 issued
    #1;
    chk("rstmid_en_pre", En, 1);
    chk("rstmid_wreg_pre", write_reg, 41);
    #1 Rst_n = 1'b0;
    #1;
    chk("rstmid_en", En, 0);
    chk("rstmid_we", reg_write, 0);
    chk("rstmid_busy", busy, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rstmid_ready", cmd_ready, 1);
    chk("rstmid_nodone", done_tot - d0, 0);
    chk("rstmid_40", mem[40], 77);
    chk("rstmid_41", mem[41], init_val(41));

`ifdef REGFILE_INIT_CHECKSUM_EN
    run_cmd(OP_FILL, 0, 50, 3, 64'd5, lat);
    chk("csum_fill", checksum, 5);
    // CMP 50..51 vs 20..21: XOR of read_data1 = 5 ^ 5 = 0
    run_cmd(OP_CMP, 50, 20, 2, 64'd0, lat);
    chk("csum_cmp", checksum, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_initiator.md
# regfile_initiator

Command-driven initiator for the 512 × 64-bit register file: accepts one block command at a time and drives the register file's read and write ports to clear, fill, copy or compare a range of registers at one element per clock. It sits between a control or test sequencer and the register file, replacing hand-driven port sequences. It reports completion with a done pulse and, for compares, a mismatch count.

## Interface
- ADDR_W, 9, register address width (512 registers)
- DATA_W, 64, register data width
- LEN_W, 10, element count width (0..512)

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  initiator idle, can accept a command
- cmd_op  in  2  operation: 00 CLEAR, 01 FILL, 10 COPY, 11 CMP
- cmd_src  in  ADDR_W  source base address (COPY, CMP)
- cmd_dst  in  ADDR_W  destination base address
- cmd_len  in  LEN_W  number of elements
- cmd_data  in  DATA_W  fill pattern (FILL)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- mismatch_cnt  out  LEN_W  CMP mismatch count; valid from done onward
- read_reg1  out  ADDR_W  register file read port 1 (source)
- read_reg2  out  ADDR_W  register file read port 2 (destination, CMP)
- read_data1  in  DATA_W  register file read data 1 (combinational)
- read_data2  in  DATA_W  register file read data 2 (combinational)
- write_reg  out  ADDR_W  register file write address
- write_data  out  DATA_W  register file write data
- reg_write  out  1  register file write strobe
- En  out  1  register file enable

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch op, src, dst, len and data.
  - Clear mismatch_cnt.
  - Go to RUN, or to DONE if cmd_len==0. A zero-length command performs no writes.
- RUN: in each cycle, element index i (from 0) is issued:
  - read_reg1 = src+i, read_reg2 = dst+i, write_reg = dst+i. Addresses wrap modulo 2^ADDR_W.
  - CLEAR: write_data=0.
  - FILL: write_data=cmd_data.
  - COPY: write_data=read_data1, combinational pass-through.
  - CLEAR, FILL and COPY assert En=reg_write=1.
  - CMP: En=reg_write=0. mismatch_cnt increments at the edge when read_data1≠read_data2.
  - After element len-1, go to DONE.
- COPY proceeds in ascending order. With overlapping ranges and dst>src, already-written values propagate; this is the defined behaviour.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy=1 exactly in RUN.
- Outside RUN:
  - En=reg_write=0.
  - Address outputs are 0.
  - write_data is 0.
- Reserved encodings: none; all four ops are legal.
- Reset values:
  - busy, done, mismatch_cnt, En, reg_write, all addresses and write_data are 0.
  - cmd_ready is 1 (IDLE decode).
- Reset mid-command is asynchronous and takes effect immediately:
  - En and reg_write drop at once.
  - The command is abandoned; writes already completed remain in the register file.
  - No done pulse is issued.

## Timing
- Handshake accepted at edge k. RUN occupies cycles k+1 .. k+len, and each write commits at the end of its cycle.
- done is high in cycle k+len+1. cmd_ready returns in cycle k+len+2.
- A len==0 command: done is high in cycle k+1.
- Throughput: len+2 cycles per command. A command cannot be accepted in the DONE cycle.
- Command inputs are sampled only at the accept edge. Changes while busy are ignored.
- mismatch_cnt holds its value until the next accept. Maximum count is 512, which fits in LEN_W.

## Configuration
- REGFILE_INIT_CHECKSUM_EN defined:
  - Adds output checksum [DATA_W-1:0].
  - For CLEAR, FILL and COPY, it is the XOR of every write_data value issued. For CMP, it is the XOR of every read_data1 value.
  - Cleared at accept and valid from done onward. Reset value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package regfile_init_pkg holds:
  - op encodings OP_CLEAR/OP_FILL/OP_COPY/OP_CMP
  - FSM state enum
  - ADDR_W/DATA_W/LEN_W defaults
- One sub-module, rf_addr_counter: the element index counter with base-plus-offset wrap and a last-element flag. It is used once for src/dst offset generation.

## Test plan
- Reset, then FILL dst=10 len=4 data=59 → regs 10..13 read 59; done in cycle k+5; reg_write high for exactly 4 cycles.
- COPY src=10 dst=20 len=4 after the above → regs 20..23 read 59; a CMP src=10 dst=20 len=4 then gives mismatch_cnt=0.
- Write 128 to reg 22, then CMP src=10 dst=20 len=4 → mismatch_cnt=1; no writes occur during CMP.
- CLEAR dst=510 len=4 → regs 510, 511, 0, 1 become 0 (wrap); reg 2 is unchanged.
- len=0 CLEAR → done one cycle after accept; En never asserts.
- Drop Rst_n in the 2nd RUN cycle of FILL len=8 → En/reg_write drop immediately, only the first element is written, no done pulse, cmd_ready=1 after release. With REGFILE_INIT_CHECKSUM_EN, FILL len=3 data=5 gives checksum=5.
